fetch_pc: RTL and testbench

- Program-counter generation stage directly upstream of the instruction-memory fetch stage.
- Drives the fetch address each cycle and tracks which PC the registered instruction word belongs to, one cycle later.
- Applies stall and branch/jump redirects, and marks wrong-path words invalid.
- Traps on misaligned or out-of-range targets.

---
 rtl/fetch_pc_if.sv | 24 ++
 rtl/fetch_pc.sv | 102 ++++++++++
 tb/tb_fetch_pc.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_if.sv
// rtl/fetch_pc_if.sv - fetch PC stage control/redirect and fetch-side status bundle
interface fetch_pc_if;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        jmp_i;
  logic [31:0] jmp_target_i;
  logic [31:0] pc_o;
  logic [31:0] pc_if_o;
  logic        valid_if_o;
  logic        flush_o;
  logic        trap_o;
  logic [31:0] bad_addr_o;

  modport master (
    output stall_i, br_taken_i, br_target_i, jmp_i, jmp_target_i,
    input  pc_o, pc_if_o, valid_if_o, flush_o, trap_o, bad_addr_o
  );

  modport slave (
    input  stall_i, br_taken_i, br_target_i, jmp_i, jmp_target_i,
    output pc_o, pc_if_o, valid_if_o, flush_o, trap_o, bad_addr_o
  );
endinterface

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - program counter generation with stall, redirect and fetch trap
module fetch_pc #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] TRAP_ADDR  = 32'h0000_0040,
  parameter int unsigned N          = 20
) (
  input  logic       clk,
  input  logic       rst,
  fetch_pc_if.slave  bus
);

  typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_if_q, pc_if_d;
  logic        valid_q, valid_d;
  logic        trap_q, trap_d;
  logic [31:0] bad_q, bad_d;
  logic        upd, redirect;
  logic [31:0] sel;

  function automatic logic is_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> 2) <= 32'(N));
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_ADDR;
      pc_if_q <= 32'h0;
      valid_q <= 1'b0;
      trap_q  <= 1'b0;
      bad_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc_if_q <= pc_if_d;
      valid_q <= valid_d;
      trap_q  <= trap_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_if_d  = pc_if_q;
    valid_d  = valid_q;
    trap_d   = 1'b0;
    bad_d    = bad_q;
    upd      = 1'b0;
    redirect = 1'b0;
    sel      = pc_q + 32'd4;

    case (state_q)
      BOOT: upd = !bus.stall_i;
      RUN: begin
        // A resolved branch overrides a stall; a decoded jump waits for it.
        if (bus.br_taken_i) begin
          upd      = 1'b1;
          redirect = 1'b1;
          sel      = bus.br_target_i;
        end else if (bus.jmp_i && !bus.stall_i) begin
          upd      = 1'b1;
          redirect = 1'b1;
          sel      = bus.jmp_target_i;
        end else begin
          upd = !bus.stall_i;
        end
      end
      TRAP: begin
        pc_d    = TRAP_ADDR;
        valid_d = 1'b0;
        state_d = RUN;
      end
      default: state_d = BOOT;
    endcase

    if (upd) begin
      pc_if_d = pc_q;
      if (is_legal(sel)) begin
        pc_d    = sel;
        valid_d = !redirect;
        state_d = RUN;
      end else begin
        bad_d   = sel;
        trap_d  = 1'b1;
        valid_d = 1'b0;
        state_d = TRAP;
      end
    end
  end

  assign bus.pc_o       = pc_q;
  assign bus.pc_if_o    = pc_if_q;
  assign bus.valid_if_o = valid_q;
  assign bus.flush_o    = redirect;
  assign bus.trap_o     = trap_q;
  assign bus.bad_addr_o = bad_q;

endmodule

// File: tb/tb_fetch_pc.sv
// tb/tb_fetch_pc.sv - directed and randomized check of fetch_pc against a reference model
module tb_fetch_pc;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] TRAP_ADDR  = 32'h0000_0040;
  localparam int unsigned N          = 20;

  logic clk;
  logic rst;
  fetch_pc_if bus();

  fetch_pc #(.RESET_ADDR(RESET_ADDR), .TRAP_ADDR(TRAP_ADDR), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // 0 = boot cycle, 1 = running, 2 = trap cycle
  int          m_state;
  logic [31:0] m_pc, m_pcif, m_bad;
  bit          m_valid, m_trap, m_init;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a / 4 <= N);
  endfunction

  task automatic model_clk(input bit r, input bit s, input bit b, input logic [31:0] bt,
                           input bit j, input logic [31:0] jt);
    logic [31:0] nxt;
    bit go, redir;
    if (!r) begin
      m_state = 0; m_pc = RESET_ADDR; m_pcif = 0; m_valid = 0; m_trap = 0; m_bad = 0;
      m_init = 1;
      return;
    end
    m_trap = 0;
    if (m_state == 2) begin
      m_pc = TRAP_ADDR; m_valid = 0; m_state = 1;
      return;
    end
    go = 0; redir = 0; nxt = m_pc + 4;
    if (m_state == 0) go = !s;
    else if (b) begin go = 1; redir = 1; nxt = bt; end
    else if (j && !s) begin go = 1; redir = 1; nxt = jt; end
    else go = !s;
    if (go) begin
      m_pcif = m_pc;
      if (legal(nxt)) begin
        m_pc = nxt; m_valid = !redir; m_state = 1;
      end else begin
        m_bad = nxt; m_trap = 1; m_valid = 0; m_state = 2;
      end
    end
  endtask

  // Called #1 after a posedge: drive, check flush, clock, check registers.
  task automatic step(input bit r, input bit s, input bit b, input logic [31:0] bt,
                      input bit j, input logic [31:0] jt);
    rst = r;
    bus.stall_i = s; bus.br_taken_i = b; bus.br_target_i = bt;
    bus.jmp_i = j; bus.jmp_target_i = jt;
    #1;
    if (m_init) check("flush", 32'(bus.flush_o), 32'((m_state == 1) && (b || (j && !s))));
    @(posedge clk);
    model_clk(r, s, b, bt, j, jt);
    #1;
    check("pc",    bus.pc_o,              m_pc);
    check("pc_if", bus.pc_if_o,           m_pcif);
    check("valid", 32'(bus.valid_if_o),   32'(m_valid));
    check("trap",  32'(bus.trap_o),       32'(m_trap));
    check("bad",   bus.bad_addr_o,        m_bad);
  endtask

  task automatic idle(input bit s);
    step(1, s, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_target();
    int k;
    k = $urandom_range(0, 9);
    if (k < 7) return 32'($urandom_range(0, N)) * 4;
    else if (k == 7) return 32'($urandom_range(0, N * 4)) | 32'd1;
    else if (k == 8) return 32'hFFFF_FFFC;
    else return (N + 1 + $urandom_range(0, 50)) * 4;
  endfunction

  initial begin
    m_init = 0;
    rst = 0;
    bus.stall_i = 0; bus.br_taken_i = 0; bus.br_target_i = 0;
    bus.jmp_i = 0; bus.jmp_target_i = 0;
    @(posedge clk); #1;

    step(0, 0, 0, 0, 0, 0);
    check("reset_pc", bus.pc_o, 32'h0);
    check("reset_valid", 32'(bus.valid_if_o), 32'h0);

    // Free run: 0,4,8
    idle(0);
    check("run_pc4", bus.pc_o, 32'h4);
    idle(0);
    check("run_pc8", bus.pc_o, 32'h8);
    check("run_pcif4", bus.pc_if_o, 32'h4);

    // Three stall cycles at pc 8
    for (int i = 0; i < 3; i++) idle(1);
    check("stall_pc", bus.pc_o, 32'h8);
    check("stall_pcif", bus.pc_if_o, 32'h4);
    check("stall_valid", 32'(bus.valid_if_o), 32'h1);
    idle(0);
    check("resume_pc", bus.pc_o, 32'hC);

    // Jump to 0x20
    step(1, 0, 0, 0, 1, 32'h20);
    check("jmp_pc", bus.pc_o, 32'h20);
    check("jmp_bubble", 32'(bus.valid_if_o), 32'h0);
    idle(0);
    check("jmp_word", bus.pc_if_o, 32'h20);
    check("jmp_valid", 32'(bus.valid_if_o), 32'h1);

    // Branch + jump + stall together: branch wins
    step(1, 1, 1, 32'h04, 1, 32'h30);
    check("br_win_pc", bus.pc_o, 32'h4);
    check("br_win_bubble", 32'(bus.valid_if_o), 32'h0);
    idle(0);

    // Misaligned and out-of-range branch targets
    step(1, 0, 1, 32'h22, 0, 0);
    check("trap22", 32'(bus.trap_o), 32'h1);
    check("bad22", bus.bad_addr_o, 32'h22);
    idle(0);
    check("trap22_pc", bus.pc_o, TRAP_ADDR);
    check("trap22_pulse", 32'(bus.trap_o), 32'h0);
    idle(0);
    check("trap22_word", bus.pc_if_o, TRAP_ADDR);
    step(1, 0, 1, 32'h60, 1, 32'h8);
    check("bad60", bus.bad_addr_o, 32'h60);
    idle(0);
    idle(0);

    // Reset during a trap cycle, then during a stall
    step(1, 0, 1, 32'h60, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("rst_trap_pc", bus.pc_o, 32'h0);
    check("rst_trap_t", 32'(bus.trap_o), 32'h0);
    idle(0); idle(0); idle(0);
    step(0, 1, 0, 0, 0, 0);
    check("rst_stall_valid", 32'(bus.valid_if_o), 32'h0);
    idle(1);
    check("boot_stall_pc", bus.pc_o, 32'h0);
    idle(0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) >= 2,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 6) == 0, rand_target(),
           $urandom_range(0, 6) == 0, rand_target());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
